frame_color_scan: RTL and testbench
===================================

// Module: frame_color_scan
// PURPOSE
//  Post-capture analysis stage: after the camera capture stage fills the RGB332 frame buffer
//  (default 160x120 = 19200 px), this block scans the buffer once per start request.
//  Each pixel is classified as red / green / blue / none. Per-colour pixel counts and
//  bounding boxes are accumulated. The block reports the dominant colour with its count and
//  box to the SoC/CPU side. It uses the buffer's second (read) port.
// PARAMETERS
//  AW        15   buffer address width; pixel k lives at address k
//  WIDTH     160  pixels per line
//  HEIGHT    120  lines per frame
//  MIN_LVL   3    min 3-bit channel level for a pixel to be classified (0..7)
//  MIN_COUNT 16   min pixel count for a colour to be reported as dominant
// PORTS
//  clk       in   1    system clock
//  rst       in   1    synchronous, active-high reset
//  start     in   1    scan request, sampled in IDLE only
//  rd_addr   out  AW   frame buffer read address
//  rd_data   in   8    RGB332 pixel {R[2:0],G[2:0],B[1:0]}, valid 1 cycle after rd_addr (sync RAM)
//  busy      out  1    high while scanning
//  done      out  1    1-cycle pulse: results updated
//  color     out  2    0 none, 1 red, 2 green, 3 blue
//  count     out  AW   pixel count of reported colour
//  x_min     out  8    bounding box of reported colour, inclusive
//  x_max     out  8
//  y_min     out  8
//  y_max     out  8
// BEHAVIOUR
//  - Reset: state IDLE; rd_addr, busy, done, color, count, x_min..y_max all 0.
//  - States: IDLE -> READ -> DRAIN -> DECIDE -> IDLE.
//  - IDLE -> READ on start==1. Cycle 0 = start sampled. N = WIDTH*HEIGHT.
//  - Accumulators are cleared on entry to READ:
//    - counts = 0
//    - per-colour x_min/y_min = 8'hFF, x_max/y_max = 0
//  - READ: rd_addr = 0,1,..,N-1 on cycles 1..N, one address per cycle. After N-1: go to DRAIN.
//  - Pipeline: rd_data seen in cycle c belongs to the address issued in cycle c-1.
//    Valid data arrives in cycles 2..N+1; DRAIN consumes the last pixel.
//  - x/y track the pixel being consumed:
//    - x counts 0..WIDTH-1, then wraps to 0 and y increments
//    - y counts 0..HEIGHT-1
//    - both restart at 0 each scan
//  - Classification: R=rd_data[7:5], G=rd_data[4:2], Bs={rd_data[1:0],rd_data[1]} (B scaled to 3 bits).
//    - red   if R>G && R>Bs && R>=MIN_LVL
//    - green if G>R && G>Bs && G>=MIN_LVL
//    - blue  if Bs>R && Bs>G && Bs>=MIN_LVL
//    - else none; any tie for the max -> none
//  - Classified pixel: increment its colour's count and widen its box with min/max of current x,y.
//  - DECIDE (cycle N+2): winner = colour with the largest count.
//    - Count ties resolve by priority red > green > blue.
//    - If the winner's count < MIN_COUNT: color=0, count=0, box all 0.
//    - Otherwise: latch color, count and box of the winner.
//  - done=1 in cycle N+3 only; outputs hold until the next DECIDE or reset.
//  - busy=1 in cycles 1..N+2; back in IDLE at cycle N+3.
//  - start while busy is ignored (no restart, no queue).
//  - start held high in IDLE from cycle N+3 begins a new scan immediately.
//  - rd_addr holds its last value (N-1) outside READ.
//  - Reset mid-scan: next cycle is IDLE with all outputs at reset values; no done pulse.
//  - Counts never overflow: N <= 2^AW-1 is required; at defaults, 19200 < 32768.
// TESTING
//  1. Buffer all 8'hE0, start -> done at cycle 19203; color=1, count=19200, box x 0..159, y 0..119.
//  2. Buffer 8'h00 except 8'h03 at x10..20, y5..9
//     -> color=3, count=55, x_min=10, x_max=20, y_min=5, y_max=9.
//  3. 100 px 8'hE0 at line 0 x0..99, 100 px 8'h1C at line 1 x0..99, rest 0
//     -> tie resolves to color=1, count=100, box 0..99, y 0..0.
//  4. Only 10 px 8'h1C, rest 8'h00 -> color=0, count=0, box all 0; done still pulses.
//  5. Pixels 8'h24 (R=G=1) and 8'hFF (R=G=7,Bs=7) only -> all none, color=0.
//  6. Start; assert rst at cycle 5000 -> IDLE next cycle, busy=0, outputs 0, no done.
//     Then start again -> full scan, valid result at cycle 19203.
//     Extra start pulses at cycles 100 and 19202 have no effect.

Source files
------------

// File: rtl/frame_color_scan.sv
// frame_color_scan
//   Scans an RGB332 frame buffer once per start request through the buffer's
//   synchronous read port. Every pixel is classified as red, green, blue or
//   none; per-colour pixel counts and bounding boxes are accumulated, and the
//   dominant colour (count >= MIN_COUNT) is reported with its count and box.
//
// Ports
//   clk      system clock
//   rst      synchronous active-high reset
//   start    scan request, honoured only while idle
//   rd_addr  frame buffer read address (pixel k at address k)
//   rd_data  RGB332 pixel {R[2:0],G[2:0],B[1:0]}, one cycle after rd_addr
//   busy     high while a scan is in progress
//   done     one-cycle pulse when the result outputs are refreshed
//   color    0 none, 1 red, 2 green, 3 blue
//   count    pixel count of the reported colour
//   x_min/x_max/y_min/y_max  inclusive bounding box of the reported colour
module frame_color_scan #(
  parameter int AW        = 15,
  parameter int WIDTH     = 160,
  parameter int HEIGHT    = 120,
  parameter int MIN_LVL   = 3,
  parameter int MIN_COUNT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic [1:0]    color,
  output logic [AW-1:0] count,
  output logic [7:0]    x_min,
  output logic [7:0]    x_max,
  output logic [7:0]    y_min,
  output logic [7:0]    y_max
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DECIDE} state_t;

  localparam logic [AW-1:0] N_LAST  = AW'(WIDTH * HEIGHT - 1);
  localparam logic [7:0]    X_LAST  = 8'(WIDTH - 1);
  localparam logic [2:0]    LVL     = 3'(MIN_LVL);
  localparam logic [AW-1:0] MIN_CNT = AW'(MIN_COUNT);

  // Strict maximum over the three channels; any tie for the top means "none".
  // Blue is widened to 3 bits by replicating its MSB so all channels span 0..7.
  function automatic logic [1:0] classify(input logic [7:0] px);
    logic [2:0] r, g, b;
    r = px[7:5];
    g = px[4:2];
    b = {px[1:0], px[1]};
    if (r > g && r > b && r >= LVL)      return 2'd1;
    else if (g > r && g > b && g >= LVL) return 2'd2;
    else if (b > r && b > g && b >= LVL) return 2'd3;
    return 2'd0;
  endfunction

  state_t          state;
  logic            vld_p1;
  logic [1:0]      cls_p1;
  logic [7:0]      x_p1, y_p1;
  logic [AW-1:0]   cnt   [1:3];
  logic [7:0]      bx_x0 [1:3];
  logic [7:0]      bx_x1 [1:3];
  logic [7:0]      bx_y0 [1:3];
  logic [7:0]      bx_y1 [1:3];
  logic [1:0]      win;

  // ---- stage p0: address issue and control ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      vld_p1  <= 1'b0;
      color   <= '0;
      count   <= '0;
      x_min   <= '0;
      x_max   <= '0;
      y_min   <= '0;
      y_max   <= '0;
    end else begin
      done   <= 1'b0;
      vld_p1 <= (state == READ);
      case (state)
        IDLE: begin
          if (start) begin
            state   <= READ;
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end
        READ: begin
          if (rd_addr == N_LAST) state <= DRAIN;
          else                   rd_addr <= rd_addr + 1'b1;
        end
        DRAIN: begin
          state <= DECIDE;
        end
        DECIDE: begin
          for (int c = 1; c <= 3; c++) begin
            if (win == 2'(c)) begin
              if (cnt[c] < MIN_CNT) begin
                color <= '0;
                count <= '0;
                x_min <= '0;
                x_max <= '0;
                y_min <= '0;
                y_max <= '0;
              end else begin
                color <= 2'(c);
                count <= cnt[c];
                x_min <= bx_x0[c];
                x_max <= bx_x1[c];
                y_min <= bx_y0[c];
                y_max <= bx_y1[c];
              end
            end
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: pixel data returned by the RAM, classify and accumulate ----
  assign cls_p1 = classify(rd_data);

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      x_p1 <= '0;
      y_p1 <= '0;
      for (int c = 1; c <= 3; c++) begin
        cnt[c]   <= '0;
        bx_x0[c] <= 8'hFF;
        bx_x1[c] <= 8'h00;
        bx_y0[c] <= 8'hFF;
        bx_y1[c] <= 8'h00;
      end
    end else if (vld_p1) begin
      if (x_p1 == X_LAST) begin
        x_p1 <= '0;
        y_p1 <= y_p1 + 8'd1;
      end else begin
        x_p1 <= x_p1 + 8'd1;
      end
      for (int c = 1; c <= 3; c++) begin
        if (cls_p1 == 2'(c)) begin
          cnt[c] <= cnt[c] + 1'b1;
          if (x_p1 < bx_x0[c]) bx_x0[c] <= x_p1;
          if (x_p1 > bx_x1[c]) bx_x1[c] <= x_p1;
          if (y_p1 < bx_y0[c]) bx_y0[c] <= y_p1;
          if (y_p1 > bx_y1[c]) bx_y1[c] <= y_p1;
        end
      end
    end
  end

  // ---- stage p2: winner selection, equal counts favour red, then green ----
  always_comb begin
    win = 2'd1;
    if (!(cnt[1] >= cnt[2] && cnt[1] >= cnt[3]))
      win = (cnt[2] >= cnt[3]) ? 2'd2 : 2'd3;
  end

endmodule

// File: tb/tb_frame_color_scan.sv
module tb_frame_color_scan;

  localparam int AW = 15;
  localparam int W  = 160;
  localparam int H  = 12;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy, done;
  logic [1:0]    color;
  logic [AW-1:0] count;
  logic [7:0]    x_min, x_max, y_min, y_max;
  logic [48:0]   res;

  logic [7:0]    mem [0:N-1];
  int            errors = 0;
  int            checks = 0;

  frame_color_scan #(.AW(AW), .WIDTH(W), .HEIGHT(H), .MIN_LVL(3), .MIN_COUNT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .color(color), .count(count),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];
  assign res = {color, count, x_min, x_max, y_min, y_max};

  function automatic logic [48:0] pack(int c, int n, int x0, int x1, int y0, int y1);
    return {2'(c), 15'(n), 8'(x0), 8'(x1), 8'(y0), 8'(y1)};
  endfunction

  // Reference: classify every buffered pixel from the channel rules, tally
  // per-colour counts and boxes, then pick the largest count.
  function automatic logic [48:0] model_result();
    int cnt[4], xmn[4], xmx[4], ymn[4], ymx[4];
    int r, g, b, mx, ties, c, x, y, best;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0; xmn[i] = 255; xmx[i] = 0; ymn[i] = 255; ymx[i] = 0;
    end
    for (int k = 0; k < N; k++) begin
      r = int'(mem[k][7:5]);
      g = int'(mem[k][4:2]);
      b = int'(mem[k][1:0]) * 2 + int'(mem[k][1]);
      mx = r;
      if (g > mx) mx = g;
      if (b > mx) mx = b;
      ties = 0;
      if (r == mx) ties++;
      if (g == mx) ties++;
      if (b == mx) ties++;
      c = 0;
      if (ties == 1 && mx >= 3) c = (r == mx) ? 1 : (g == mx) ? 2 : 3;
      if (c != 0) begin
        x = k % W;
        y = k / W;
        cnt[c]++;
        if (x < xmn[c]) xmn[c] = x;
        if (x > xmx[c]) xmx[c] = x;
        if (y < ymn[c]) ymn[c] = y;
        if (y > ymx[c]) ymx[c] = y;
      end
    end
    best = 1;
    if (cnt[2] > cnt[best]) best = 2;
    if (cnt[3] > cnt[best]) best = 3;
    if (cnt[best] < 16) return '0;
    return pack(best, cnt[best], xmn[best], xmx[best], ymn[best], ymx[best]);
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int k = 0; k < N; k++) mem[k] = v;
  endtask

  task automatic rect(input int x0, input int x1, input int y0, input int y1, input logic [7:0] v);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) mem[y * W + x] = v;
  endtask

  // Pulses start for one cycle and waits (bounded) for done; lat is the cycle
  // index of done counted from the start-sampling edge, -1 on timeout.
  task automatic run_scan(output int lat, output logic b1, output logic [AW-1:0] a1,
                          output logic bend);
    logic prev_busy;
    lat = -1; b1 = 1'b0; a1 = '0; bend = 1'b0; prev_busy = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= N + 50; n++) begin
      @(negedge clk);
      if (n == 1) begin b1 = busy; a1 = rd_addr; end
      if (done) begin lat = n; bend = prev_busy; break; end
      prev_busy = busy;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (res !== 49'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", res); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
    rst = 1'b0;
  endtask

  task automatic test_all_red;
    int lat; logic b1, bend; logic [AW-1:0] a1;
    fill(8'hE0);
    run_scan(lat, b1, a1, bend);
    checks++; if (lat !== N + 3) begin errors++; $display("FAIL red_latency got=%0d exp=%0d", lat, N + 3); end
    checks++; if (res !== pack(1, N, 0, W - 1, 0, H - 1)) begin errors++; $display("FAIL red_result got=%h exp=%h", res, pack(1, N, 0, W - 1, 0, H - 1)); end
    checks++; if (b1 !== 1'b1 || bend !== 1'b1) begin errors++; $display("FAIL red_busy_window got=%b%b exp=11", b1, bend); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL red_busy_at_done got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL red_done_width got=%b exp=0", done); end
    checks++; if (rd_addr !== AW'(N - 1)) begin errors++; $display("FAIL red_addr_hold got=%0d exp=%0d", rd_addr, N - 1); end
  endtask

  task automatic test_blue_box;
    int lat; logic b1, bend; logic [AW-1:0] a1;
    fill(8'h00);
    rect(10, 20, 5, 9, 8'h03);
    run_scan(lat, b1, a1, bend);
    checks++; if (a1 !== '0) begin errors++; $display("FAIL blue_first_addr got=%0d exp=0", a1); end
    checks++; if (res !== pack(3, 55, 10, 20, 5, 9)) begin errors++; $display("FAIL blue_result got=%h exp=%h", res, pack(3, 55, 10, 20, 5, 9)); end
  endtask

  task automatic test_count_tie;
    int lat; logic b1, bend; logic [AW-1:0] a1;
    fill(8'h00);
    rect(0, 99, 0, 0, 8'hE0);
    rect(0, 99, 1, 1, 8'h1C);
    run_scan(lat, b1, a1, bend);
    checks++; if (res !== pack(1, 100, 0, 99, 0, 0)) begin errors++; $display("FAIL tie_result got=%h exp=%h", res, pack(1, 100, 0, 99, 0, 0)); end
  endtask

  task automatic test_min_count;
    int lat; logic b1, bend; logic [AW-1:0] a1;
    fill(8'h00);
    rect(0, 9, 3, 3, 8'h1C);
    run_scan(lat, b1, a1, bend);
    checks++; if (lat !== N + 3) begin errors++; $display("FAIL below_min_done got=%0d exp=%0d", lat, N + 3); end
    checks++; if (res !== 49'd0) begin errors++; $display("FAIL below_min_result got=%h exp=0", res); end
    fill(8'h00);
    rect(40, 47, 6, 7, 8'h03);
    run_scan(lat, b1, a1, bend);
    checks++; if (res !== pack(3, 16, 40, 47, 6, 7)) begin errors++; $display("FAIL at_min_result got=%h exp=%h", res, pack(3, 16, 40, 47, 6, 7)); end
  endtask

  task automatic test_channel_ties;
    int lat; logic b1, bend; logic [AW-1:0] a1;
    for (int k = 0; k < N; k++) mem[k] = (k % 2 == 0) ? 8'h24 : 8'hFF;
    run_scan(lat, b1, a1, bend);
    checks++; if (res !== 49'd0) begin errors++; $display("FAIL channel_tie_result got=%h exp=0", res); end
  endtask

  task automatic test_random;
    int lat; logic b1, bend; logic [AW-1:0] a1;
    logic [48:0] exp;
    int x0, x1, y0, y1;
    for (int f = 0; f < 3; f++) begin
      if (f == 0) begin
        for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
      end else begin
        fill(8'($urandom_range(0, 3) * 32));
        for (int r = 0; r < 4; r++) begin
          x0 = $urandom_range(0, W - 1); x1 = $urandom_range(x0, W - 1);
          y0 = $urandom_range(0, H - 1); y1 = $urandom_range(y0, H - 1);
          rect(x0, x1, y0, y1, 8'($urandom));
        end
      end
      exp = model_result();
      run_scan(lat, b1, a1, bend);
      checks++; if (lat !== N + 3) begin errors++; $display("FAIL random%0d_latency got=%0d exp=%0d", f, lat, N + 3); end
      checks++; if (res !== exp) begin errors++; $display("FAIL random%0d_result got=%h exp=%h", f, res, exp); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, lat2;
    logic [48:0] exp;
    fill(8'h00);
    rect(3, 30, 2, 8, 8'h1C);
    exp = model_result();
    lat = -1; lat2 = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= N + 50; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
    checks++; if (lat !== N + 3) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, N + 3); end
    checks++; if (res !== exp) begin errors++; $display("FAIL b2b_first_result got=%h exp=%h", res, exp); end
    fill(8'h00);
    rect(50, 70, 4, 10, 8'hE0);
    exp = model_result();
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got=%b exp=1", busy); end
    for (int n = 2; n <= N + 50; n++) begin
      @(negedge clk);
      if (done) begin lat2 = n; break; end
    end
    checks++; if (lat2 !== N + 3) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat2, N + 3); end
    checks++; if (res !== exp) begin errors++; $display("FAIL b2b_second_result got=%h exp=%h", res, exp); end
  endtask

  task automatic test_reset_mid_scan;
    int lat, ndone, saw_done;
    logic b4;
    logic [48:0] exp;
    fill(8'h00);
    rect(100, 140, 0, 11, 8'h1C);
    exp = model_result();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 500; n++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (res !== 49'd0 || rd_addr !== '0) begin errors++; $display("FAIL midrst_outputs got=%h addr=%0d exp=0", res, rd_addr); end
    saw_done = 0;
    for (int n = 0; n < N + 10; n++) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    checks++; if (saw_done !== 0) begin errors++; $display("FAIL midrst_quiet got=%0d exp=0", saw_done); end
    lat = -1; ndone = 0; b4 = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= N + 6; n++) begin
      @(negedge clk);
      if (done) begin ndone++; if (lat < 0) lat = n; end
      if (n == N + 4) b4 = busy;
      start = (n == 100 || n == N + 2);
    end
    start = 1'b0;
    checks++; if (lat !== N + 3 || ndone !== 1) begin errors++; $display("FAIL extra_start_done got=%0d/%0d exp=%0d/1", lat, ndone, N + 3); end
    checks++; if (b4 !== 1'b0) begin errors++; $display("FAIL extra_start_idle got=%b exp=0", b4); end
    checks++; if (res !== exp) begin errors++; $display("FAIL rescan_result got=%h exp=%h", res, exp); end
  endtask

  initial begin
    fill(8'h00);
    test_reset();
    test_all_red();
    test_blue_box();
    test_count_tie();
    test_min_count();
    test_channel_ties();
    test_random();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
